// File: rtl/glyph_raster_pkg.sv
// Shared display package for the glyph rasterizer.
// Holds the default glyph geometry, the screen size, the pixel coordinate
// width, and a helper that computes a pixel's offset from a glyph origin.
package glyph_raster_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 1024;
    localparam int GLYPH_W  = 5;
    localparam int GLYPH_H  = 5;

    // One bit wider than a coordinate. A pixel left of or above the origin
    // gives a result of 1024 or more, so it can never fall inside the glyph
    // window. This is what clips a glyph at column/row 1023 instead of
    // letting it wrap to column/row 0.
    localparam int OFF_W = COORD_W + 1;
    localparam int ROW_W = 3;

    function automatic logic [OFF_W-1:0] coord_offset(
        input logic [COORD_W-1:0] pix,
        input logic [COORD_W-1:0] org
    );
        return {1'b0, pix} - {1'b0, org};
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink frame counter for the glyph rasterizer.
// Ports:
//   clk, reset   single clock; synchronous active-high reset
//   frame_start  one-cycle pulse at the start of each frame
//   blink_en     enable blinking
//   visible      glyph visibility; changes only at frame_start, except that
//                dropping blink_en forces it to 1 on the next cycle
module blink_timer #(
    parameter int BLINK_FRAMES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    input  logic blink_en,
    output logic visible
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
    localparam bit BLINK_ON = (BLINK_FRAMES > 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             visible_q, visible_d;

    always_comb begin
        cnt_d     = cnt_q;
        visible_d = visible_q;
        if (!BLINK_ON || !blink_en) begin
            cnt_d     = '0;
            visible_d = 1'b1;
        end else if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                visible_d = !visible_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            visible_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            visible_q <= visible_d;
        end
    end

    assign visible = visible_q;

endmodule

// File: rtl/glyph_raster.sv
// Glyph rasterizer: overlays a GLYPH_W x GLYPH_H glyph at a programmable
// screen position. The glyph can optionally blink.
// Ports:
//   clk, reset           single clock; synchronous active-high reset
//   pix_x, pix_y         current pixel, qualified by pix_valid
//   frame_start          one-cycle pulse at the start of each frame
//   pos_x, pos_y         requested glyph origin, captured by pos_load
//   blink_en             enable blinking
//   rom_row / rom_code   external row-code lookup; rom_code is combinational
//                        and bit GLYPH_W-1 is the leftmost pixel
//   pix_on, pix_on_valid result for the pixel presented 2 cycles earlier
module glyph_raster #(
    parameter int GLYPH_W      = glyph_raster_pkg::GLYPH_W,
    parameter int GLYPH_H      = glyph_raster_pkg::GLYPH_H,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [glyph_raster_pkg::COORD_W-1:0] pix_x,
    input  logic [glyph_raster_pkg::COORD_W-1:0] pix_y,
    input  logic                                 pix_valid,
    input  logic                                 frame_start,
    input  logic [glyph_raster_pkg::COORD_W-1:0] pos_x,
    input  logic [glyph_raster_pkg::COORD_W-1:0] pos_y,
    input  logic                                 pos_load,
    input  logic                                 blink_en,
    output logic [glyph_raster_pkg::ROW_W-1:0]   rom_row,
    input  logic [GLYPH_W-1:0]                   rom_code,
    output logic                                 pix_on,
    output logic                                 pix_on_valid
);

    import glyph_raster_pkg::*;

    logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
    logic               hit_q, hit_d, s1_valid_q, s1_valid_d;
    logic [ROW_W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic               pix_on_q, pix_on_d, pix_on_valid_q, pix_on_valid_d;
    logic [OFF_W-1:0]   off_x, off_y;
    logic               code_bit;
    logic               visible;

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_timer (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .blink_en   (blink_en),
        .visible    (visible)
    );

    always_comb begin
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        if (pos_load) begin
            pend_x_d = pos_x;
            pend_y_d = pos_y;
        end
        // Take the active position from pend_*_d, not pend_*_q. A load in
        // the same cycle as frame_start then takes effect at that frame.
        if (frame_start) begin
            act_x_d = pend_x_d;
            act_y_d = pend_y_d;
        end

        // Stage 1: window test against the active origin.
        off_x      = coord_offset(pix_x, act_x_q);
        off_y      = coord_offset(pix_y, act_y_q);
        hit_d      = pix_valid && (off_x < OFF_W'(GLYPH_W)) && (off_y < OFF_W'(GLYPH_H));
        dx_d       = off_x[ROW_W-1:0];
        dy_d       = off_y[ROW_W-1:0];
        s1_valid_d = pix_valid;

        // Stage 2: pick the column bit. Bit GLYPH_W-1 is dx = 0.
        code_bit = 1'b0;
        for (int i = 0; i < GLYPH_W; i++) begin
            if (dx_q == ROW_W'(GLYPH_W - 1 - i)) begin
                code_bit = rom_code[i];
            end
        end
        pix_on_d       = hit_q && visible && code_bit;
        pix_on_valid_d = s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_x_q       <= '0;
            pend_y_q       <= '0;
            act_x_q        <= '0;
            act_y_q        <= '0;
            hit_q          <= 1'b0;
            s1_valid_q     <= 1'b0;
            dx_q           <= '0;
            dy_q           <= '0;
            pix_on_q       <= 1'b0;
            pix_on_valid_q <= 1'b0;
        end else begin
            pend_x_q       <= pend_x_d;
            pend_y_q       <= pend_y_d;
            act_x_q        <= act_x_d;
            act_y_q        <= act_y_d;
            hit_q          <= hit_d;
            s1_valid_q     <= s1_valid_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            pix_on_q       <= pix_on_d;
            pix_on_valid_q <= pix_on_valid_d;
        end
    end

    assign rom_row      = hit_q ? dy_q : '0;
    assign pix_on       = pix_on_q;
    assign pix_on_valid = pix_on_valid_q;

endmodule

// File: doc/glyph_raster.md
GLYPH_RASTER -- requirements
Module: glyph_raster

Interface
REQ-001 Parameter GLYPH_W, default 5: glyph width in pixels, equal to the row-code width.
REQ-002 Parameter GLYPH_H, default 5: glyph height in rows.
REQ-003 Parameter BLINK_FRAMES, default 32: frames per visibility half-period; 0 disables blinking.
REQ-004 clk  in  1  single clock; one clock and one synchronous active-high reset.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 pix_x  in  10  current pixel column.
REQ-007 pix_y  in  10  current pixel row.
REQ-008 pix_valid  in  1  pix_x/pix_y qualify a visible pixel this cycle.
REQ-009 frame_start  in  1  one-cycle pulse at start of each frame.
REQ-010 pos_x  in  10  requested glyph left column.
REQ-011 pos_y  in  10  requested glyph top row.
REQ-012 pos_load  in  1  capture pos_x/pos_y into the pending register.
REQ-013 blink_en  in  1  enable blinking.
REQ-014 rom_row  out  3  row index to the external row-code lookup, 0..GLYPH_H-1.
REQ-015 rom_code  in  GLYPH_W  combinational row code returned for rom_row; bit GLYPH_W-1 is the leftmost pixel.
REQ-016 pix_on  out  1  glyph pixel lit.
REQ-017 pix_on_valid  out  1  pix_on qualifies the pixel presented 2 cycles earlier.

Function
REQ-018 pos_load SHALL copy pos_x/pos_y into a pending register; the active position SHALL update from pending only on frame_start.
REQ-019 pos_load and frame_start in the same cycle SHALL make the newly loaded position active at that frame start.
REQ-020 Stage 1 SHALL register hit = pix_valid & (pix_x - act_x) in [0,GLYPH_W-1] & (pix_y - act_y) in [0,GLYPH_H-1], plus dx, dy (3 bits each) and pix_valid.
REQ-021 Offsets SHALL be computed at 11 bits; glyphs overlapping column/row 1023 SHALL be clipped, with no wrap-around to column/row 0.
REQ-022 rom_row SHALL equal registered dy when hit is set, else 0.
REQ-023 Stage 2 SHALL register pix_on = hit & visible & rom_code[GLYPH_W-1-dx], and pix_on_valid = stage-1 valid.
REQ-024 Fixed latency SHALL be 2 cycles from pix_valid to pix_on_valid; throughput SHALL be one pixel per cycle with no stalls.
REQ-025 A frame counter SHALL increment on frame_start; on reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle visible.
REQ-026 With blink_en=0 or BLINK_FRAMES=0, visible SHALL be held at 1 and the counter SHALL be held at 0.
REQ-027 A blink_en 1->0 transition SHALL set visible to 1 on the next cycle.
REQ-028 Visibility changes SHALL take effect only at frame_start, never mid-frame.

Reset
REQ-029 Reset SHALL clear pix_on, pix_on_valid, rom_row, all pipeline valids, the frame counter, and the active and pending positions (0,0), and SHALL set visible to 1.
REQ-030 Reset asserted mid-frame SHALL drop in-flight pixels; pix_on_valid SHALL be 0 in the cycle after reset is sampled.
REQ-031 After reset releases, the glyph SHALL remain at (0,0) until pos_load followed by frame_start.

Structure
REQ-032 GLYPH_W, GLYPH_H, the screen width/height constants (1024) and the coordinate width (10) SHALL reside in the shared display package.
REQ-033 The blink frame counter SHALL be the single sub-module, blink_timer; the row-code lookup SHALL remain external.

Verification
REQ-034 Load pos (100,50), pulse frame_start, present pixel (100,50) with rom_code 10011 -> pix_on=1, pix_on_valid=1 two cycles later, rom_row=0.
REQ-035 Same frame: pixels (101,50), (102,50), (103,50) -> pix_on 0, 0, 1; pixel (105,50) -> pix_on 0 (outside window).
REQ-036 pos_load (200,60) mid-frame without frame_start -> the glyph stays at (100,50); after frame_start, pixel (202,62) with rom_code 00100 -> pix_on=1, rom_row=2.
REQ-037 pos (1021,0), pixels (1023,0) and then (0,0), rom_code 11111 -> pix_on 1, then 0 (no wrap).
REQ-038 blink_en=1, BLINK_FRAMES=2, glyph pixel lit each frame -> pix_on pattern 1,1,0,0,1,1 across six frames; blink_en=0 -> always 1.
REQ-039 Reset asserted between two valid pixels -> pix_on_valid=0 the next cycle, position returns to (0,0), and visible=1.
